// File: rtl/yutorina_spr_arb_if.sv
// rtl/yutorina_spr_arb_if.sv - requester, SPR port and response bundle for the SPR arbiter
interface yutorina_spr_arb_if #(
  parameter int NREQ   = 3,
  parameter int ID_W   = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_we;
  logic [NREQ-1:0]        req_lock;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        req_ready;
  logic [ADDR_W-1:0]      spr_r_addr;
  logic [ADDR_W-1:0]      spr_w_addr;
  logic [DATA_W-1:0]      spr_w_data;
  logic                   spr_we_;
  logic [DATA_W-1:0]      spr_r_data;
  logic                   rsp_valid;
  logic [ID_W-1:0]        rsp_id;
  logic                   rsp_we;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   lock_err;

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, spr_r_data,
    input  req_ready, spr_r_addr, spr_w_addr, spr_w_data, spr_we_,
    input  rsp_valid, rsp_id, rsp_we, rsp_rdata, lock_err
  );

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, spr_r_data,
    output req_ready, spr_r_addr, spr_w_addr, spr_w_data, spr_we_,
    output rsp_valid, rsp_id, rsp_we, rsp_rdata, lock_err
  );
endinterface

// File: rtl/yutorina_spr_arb.sv
// rtl/yutorina_spr_arb.sv - round-robin arbiter with RMW lock for a single-ported SPR file
// Accept at t, drive the SPR port at t+1, registered response at t+2.
module yutorina_spr_arb #(
  parameter int NREQ    = 3,
  parameter int ID_W    = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int LOCK_TO = 15
) (
  input logic               clk,
  input logic               rst,
  yutorina_spr_arb_if.slave bus
);

  logic [ID_W-1:0]   r_rr_ptr;
  logic              r_lock_act;
  logic [ID_W-1:0]   r_lock_id;
  logic [7:0]        r_lock_cnt;
  logic              r_lock_err;

  logic              r_iss_v;
  logic [ID_W-1:0]   r_iss_id;
  logic              r_iss_we;
  logic [ADDR_W-1:0] r_iss_addr;
  logic [DATA_W-1:0] r_iss_wdata;

  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic              r_rsp_we;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic [NREQ-1:0]   w_elig;
  logic              w_any;
  logic [ID_W-1:0]   w_win;
  logic [ID_W:0]     w_sum;
  logic [ID_W-1:0]   w_cand;
  logic [ID_W-1:0]   w_next;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  logic              w_own_v;

  // A held lock narrows eligibility to the owner; the search starts at r_rr_ptr.
  always_comb begin
    w_elig = r_lock_act ? (bus.req_valid & (NREQ'(1) << r_lock_id)) : bus.req_valid;
    w_any  = 1'b0;
    w_win  = '0;
    w_sum  = '0;
    w_cand = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(NREQ)) w_sum = w_sum - (ID_W+1)'(NREQ);
      w_cand = w_sum[ID_W-1:0];
      if (!w_any && w_elig[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  assign w_next      = (w_win == ID_W'(NREQ-1)) ? '0 : w_win + 1'b1;
  assign w_win_addr  = bus.req_addr[w_win*ADDR_W +: ADDR_W];
  assign w_win_wdata = bus.req_wdata[w_win*DATA_W +: DATA_W];
  assign w_own_v     = bus.req_valid[r_lock_id];

  assign bus.req_ready  = w_any ? (NREQ'(1) << w_win) : '0;
  assign bus.spr_r_addr = r_iss_addr;
  assign bus.spr_w_addr = r_iss_addr;
  assign bus.spr_w_data = r_iss_wdata;
  // The reset cycle must never commit a write even though the issue stage is still full.
  assign bus.spr_we_    = ~(r_iss_v & r_iss_we & ~rst);
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_we     = r_rsp_we;
  assign bus.rsp_rdata  = r_rsp_rdata;
  assign bus.lock_err   = r_lock_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_lock_act  <= 1'b0;
      r_lock_id   <= '0;
      r_lock_cnt  <= '0;
      r_lock_err  <= 1'b0;
      r_iss_v     <= 1'b0;
      r_iss_id    <= '0;
      r_iss_we    <= 1'b0;
      r_iss_addr  <= '0;
      r_iss_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_we    <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_lock_err <= 1'b0;
      // Timeout and owner acceptance are exclusive: an idle owner cannot be granted.
      if (r_lock_act && !w_own_v) begin
        if (r_lock_cnt == 8'(LOCK_TO-1)) begin
          r_lock_act <= 1'b0;
          r_lock_cnt <= '0;
          r_lock_err <= 1'b1;
        end else begin
          r_lock_cnt <= r_lock_cnt + 8'd1;
        end
      end else begin
        r_lock_cnt <= '0;
      end

      r_iss_v <= w_any;
      if (w_any) begin
        r_iss_id    <= w_win;
        r_iss_we    <= bus.req_we[w_win];
        r_iss_addr  <= w_win_addr;
        r_iss_wdata <= w_win_wdata;
        r_rr_ptr    <= w_next;
        if (bus.req_lock[w_win]) begin
          r_lock_act <= 1'b1;
          r_lock_id  <= w_win;
        end else if (w_win == r_lock_id) begin
          r_lock_act <= 1'b0;
        end
      end

      r_rsp_valid <= r_iss_v;
      if (r_iss_v) begin
        r_rsp_id    <= r_iss_id;
        r_rsp_we    <= r_iss_we;
        r_rsp_rdata <= r_iss_we ? '0 : bus.spr_r_data;
      end
    end
  end

endmodule

// File: tb/tb_yutorina_spr_arb.sv
// tb/tb_yutorina_spr_arb.sv - scenario and randomized checks of yutorina_spr_arb against a queue model
module tb_yutorina_spr_arb;
  localparam int NREQ = 3, ID_W = 2, ADDR_W = 5, DATA_W = 32, LOCK_TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_clr = 1'b1;
  always #5 clk = ~clk;

  yutorina_spr_arb_if #(.NREQ(NREQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
  yutorina_spr_arb #(.NREQ(NREQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_TO(LOCK_TO))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));

  logic [DATA_W-1:0] spr_mem [32];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) spr_mem[i] <= '0;
    end else if (bus.spr_we_ === 1'b0) begin
      spr_mem[bus.spr_w_addr] <= bus.spr_w_data;
    end
  end
  assign bus.spr_r_data = spr_mem[bus.spr_r_addr];

  int n_checks = 0, n_pass = 0;

  typedef struct { int due; int id; bit we; logic [DATA_W-1:0] rdata; } rsp_t;
  rsp_t exp_q[$];
  logic [DATA_W-1:0] shadow [32];
  int  m_ptr, m_lock_id, m_idle, m_cyc;
  bit  m_lock_act, m_err_exp;
  bit  iss_v, iss_we;
  int  iss_addr;
  logic [DATA_W-1:0] iss_wdata;

  int  e_win;
  logic [NREQ-1:0] e_ready;
  bit  e_rv, e_spr_wr;
  rsp_t e_rsp;

  task automatic model_eval();
    e_win = -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (e_win < 0 && bus.req_valid[i] && (!m_lock_act || i == m_lock_id)) e_win = i;
    end
    e_ready = (e_win < 0) ? '0 : NREQ'(1) << e_win;
    e_rv = (exp_q.size() > 0) && (exp_q[0].due == m_cyc);
    if (e_rv) e_rsp = exp_q[0];
    e_spr_wr = !rst && iss_v && iss_we;
  endtask

  task automatic model_commit();
    rsp_t r;
    if (rst) begin
      m_ptr = 0; m_lock_act = 0; m_lock_id = 0; m_idle = 0; m_err_exp = 0;
      exp_q.delete(); iss_v = 0;
    end else begin
      if (iss_v && iss_we) shadow[iss_addr] = iss_wdata;
      if (exp_q.size() > 0 && exp_q[0].due == m_cyc) void'(exp_q.pop_front());
      m_err_exp = 0;
      if (m_lock_act && !bus.req_valid[m_lock_id]) begin
        m_idle++;
        if (m_idle == LOCK_TO) begin m_lock_act = 0; m_idle = 0; m_err_exp = 1; end
      end else m_idle = 0;
      iss_v = (e_win >= 0);
      if (iss_v) begin
        iss_we    = bus.req_we[e_win];
        iss_addr  = int'(bus.req_addr[e_win*ADDR_W +: ADDR_W]);
        iss_wdata = bus.req_wdata[e_win*DATA_W +: DATA_W];
        r.due = m_cyc + 2; r.id = e_win; r.we = iss_we;
        r.rdata = iss_we ? '0 : shadow[iss_addr];
        exp_q.push_back(r);
        m_ptr = (e_win + 1) % NREQ;
        if (bus.req_lock[e_win]) begin m_lock_act = 1; m_lock_id = e_win; end
        else if (e_win == m_lock_id) m_lock_act = 0;
      end
    end
    m_cyc++;
  endtask

  task automatic cyc_eval();
    @(negedge clk);
    model_eval();
  endtask

  task automatic cyc_end();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0; bus.req_we = '0; bus.req_lock = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    cyc_end();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    cyc_end();
    cyc_end();
    rst = 1'b0;
    mem_clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc_eval();
      n_checks++; if (bus.req_ready !== 3'b000) $display("FAIL reset_ready cyc=%0d got=%b exp=000", k, bus.req_ready); else n_pass++;
      n_checks++; if (bus.spr_we_ !== 1'b1) $display("FAIL reset_spr_we_ cyc=%0d got=%b exp=1", k, bus.spr_we_); else n_pass++;
      n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid cyc=%0d got=%b exp=0", k, bus.rsp_valid); else n_pass++;
      n_checks++; if (bus.lock_err !== 1'b0) $display("FAIL reset_lock_err cyc=%0d got=%b exp=0", k, bus.lock_err); else n_pass++;
      cyc_end();
    end
  endtask

  task automatic test_write_read();
    apply_reset();
    bus.req_valid = 3'b010; bus.req_we = 3'b010;
    bus.req_addr[1*ADDR_W +: ADDR_W] = 5'd3;
    bus.req_wdata[1*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    cyc_eval();
    n_checks++; if (bus.req_ready !== 3'b010) $display("FAIL wr_ready got=%b exp=010", bus.req_ready); else n_pass++;
    cyc_end();
    idle_inputs();
    bus.req_valid = 3'b001; bus.req_addr[0 +: ADDR_W] = 5'd3;
    cyc_eval();
    n_checks++; if (bus.req_ready !== 3'b001) $display("FAIL rd_ready got=%b exp=001", bus.req_ready); else n_pass++;
    n_checks++; if (bus.spr_we_ !== 1'b0) $display("FAIL wr_spr_we_ got=%b exp=0", bus.spr_we_); else n_pass++;
    n_checks++; if (bus.spr_w_addr !== 5'd3) $display("FAIL wr_w_addr got=%0d exp=3", bus.spr_w_addr); else n_pass++;
    n_checks++; if (bus.spr_w_data !== 32'hDEAD_BEEF) $display("FAIL wr_w_data got=%h exp=deadbeef", bus.spr_w_data); else n_pass++;
    cyc_end();
    idle_inputs();
    cyc_eval();
    n_checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_we} !== {1'b1, 2'd1, 1'b1}) $display("FAIL wr_rsp got=v%b id%0d we%b exp=v1 id1 we1", bus.rsp_valid, bus.rsp_id, bus.rsp_we); else n_pass++;
    n_checks++; if (bus.rsp_rdata !== 32'h0) $display("FAIL wr_rsp_rdata got=%h exp=0", bus.rsp_rdata); else n_pass++;
    cyc_end();
    cyc_eval();
    n_checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_we} !== {1'b1, 2'd0, 1'b0}) $display("FAIL rd_rsp got=v%b id%0d we%b exp=v1 id0 we0", bus.rsp_valid, bus.rsp_id, bus.rsp_we); else n_pass++;
    n_checks++; if (bus.rsp_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_rsp_rdata got=%h exp=deadbeef", bus.rsp_rdata); else n_pass++;
    cyc_end();
  endtask

  task automatic test_round_robin();
    apply_reset();
    bus.req_valid = 3'b111; bus.req_we = 3'b000;
    for (int i = 0; i < NREQ; i++) bus.req_addr[i*ADDR_W +: ADDR_W] = 5'd3;
    for (int k = 0; k < 8; k++) begin
      cyc_eval();
      if (k < 6) begin
        n_checks++; if (bus.req_ready !== (NREQ'(1) << (k % 3))) $display("FAIL rr_ready k=%0d got=%b exp=%b", k, bus.req_ready, NREQ'(1) << (k % 3)); else n_pass++;
      end
      n_checks++; if (bus.rsp_valid !== (k >= 2)) $display("FAIL rr_rsp_valid k=%0d got=%b exp=%b", k, bus.rsp_valid, k >= 2); else n_pass++;
      if (k >= 2) begin
        n_checks++; if (bus.rsp_id !== ID_W'((k - 2) % 3)) $display("FAIL rr_rsp_id k=%0d got=%0d exp=%0d", k, bus.rsp_id, (k - 2) % 3); else n_pass++;
        n_checks++; if (bus.rsp_rdata !== 32'hDEAD_BEEF) $display("FAIL rr_rsp_rdata k=%0d got=%h exp=deadbeef", k, bus.rsp_rdata); else n_pass++;
      end
      cyc_end();
      if (k == 5) bus.req_valid = '0;
    end
  endtask

  task automatic test_lock();
    logic [NREQ-1:0] exp_rdy [7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      begin bus.req_valid = 3'b100; bus.req_lock = 3'b100; end
      else if (k < 5)  begin bus.req_valid = 3'b111; bus.req_lock = 3'b100; end
      else if (k == 5) begin bus.req_valid = 3'b111; bus.req_lock = 3'b000; end
      else if (k == 6) begin bus.req_valid = 3'b011; bus.req_lock = 3'b000; end
      else idle_inputs();
      cyc_eval();
      if (k < 7) begin
        n_checks++; if (bus.req_ready !== exp_rdy[k]) $display("FAIL lock_ready k=%0d got=%b exp=%b", k, bus.req_ready, exp_rdy[k]); else n_pass++;
      end
      n_checks++; if (bus.rsp_valid !== e_rv) $display("FAIL lock_rsp_valid k=%0d got=%b exp=%b", k, bus.rsp_valid, e_rv); else n_pass++;
      if (e_rv) begin
        n_checks++; if (bus.rsp_id !== ID_W'(e_rsp.id)) $display("FAIL lock_rsp_id k=%0d got=%0d exp=%0d", k, bus.rsp_id, e_rsp.id); else n_pass++;
      end
      cyc_end();
    end
  endtask

  task automatic test_lock_timeout();
    int blocked = 0, errs = 0;
    bit granted = 0;
    apply_reset();
    bus.req_valid = 3'b010; bus.req_lock = 3'b010;
    cyc_eval();
    n_checks++; if (bus.req_ready !== 3'b010) $display("FAIL to_lock_ready got=%b exp=010", bus.req_ready); else n_pass++;
    cyc_end();
    bus.req_valid = 3'b001; bus.req_lock = 3'b000;
    for (int k = 0; k < 40 && !granted; k++) begin
      cyc_eval();
      n_checks++; if (bus.req_ready !== e_ready) $display("FAIL to_ready k=%0d got=%b exp=%b", k, bus.req_ready, e_ready); else n_pass++;
      n_checks++; if (bus.lock_err !== m_err_exp) $display("FAIL to_lock_err k=%0d got=%b exp=%b", k, bus.lock_err, m_err_exp); else n_pass++;
      if (bus.lock_err === 1'b1) errs++;
      if (bus.req_ready[0] === 1'b1) granted = 1; else blocked++;
      cyc_end();
    end
    idle_inputs();
    n_checks++; if (!granted || blocked != LOCK_TO) $display("FAIL to_blocked got=%0d granted=%0d exp=%0d", blocked, granted, LOCK_TO); else n_pass++;
    n_checks++; if (errs != 1) $display("FAIL to_err_pulses got=%0d exp=1", errs); else n_pass++;
    for (int k = 0; k < 3; k++) begin cyc_eval(); cyc_end(); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.req_valid = 3'b001; bus.req_we = 3'b001;
    bus.req_addr[0 +: ADDR_W] = 5'd7; bus.req_wdata[0 +: DATA_W] = 32'h1234_5678;
    cyc_eval();
    cyc_end();
    idle_inputs();
    rst = 1'b1;
    cyc_eval();
    n_checks++; if (bus.spr_we_ !== 1'b1) $display("FAIL mid_spr_we_ got=%b exp=1", bus.spr_we_); else n_pass++;
    cyc_end();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc_eval();
      n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL mid_rsp_valid k=%0d got=%b exp=0", k, bus.rsp_valid); else n_pass++;
      cyc_end();
    end
    n_checks++; if (spr_mem[7] !== shadow[7]) $display("FAIL mid_spr_mem7 got=%h exp=%h", spr_mem[7], shadow[7]); else n_pass++;
    bus.req_valid = 3'b011;
    cyc_eval();
    n_checks++; if (bus.req_ready !== 3'b001) $display("FAIL mid_first_grant got=%b exp=001", bus.req_ready); else n_pass++;
    cyc_end();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin cyc_eval(); cyc_end(); end
  endtask

  task automatic test_random();
    bit pend [NREQ];
    apply_reset();
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && k < 390 && $urandom_range(0, 1) == 1) begin
          pend[i] = 1;
          bus.req_we[i] = 1'($urandom_range(0, 1));
          bus.req_lock[i] = ($urandom_range(0, 5) == 0);
          bus.req_addr[i*ADDR_W +: ADDR_W] = 5'($urandom_range(0, 7));
          bus.req_wdata[i*DATA_W +: DATA_W] = $urandom;
        end
        bus.req_valid[i] = pend[i];
      end
      cyc_eval();
      n_checks++; if (bus.req_ready !== e_ready) $display("FAIL rnd_ready k=%0d got=%b exp=%b", k, bus.req_ready, e_ready); else n_pass++;
      n_checks++; if (bus.rsp_valid !== e_rv) $display("FAIL rnd_rsp_valid k=%0d got=%b exp=%b", k, bus.rsp_valid, e_rv); else n_pass++;
      if (e_rv) begin
        n_checks++; if ({bus.rsp_id, bus.rsp_we} !== {ID_W'(e_rsp.id), e_rsp.we}) $display("FAIL rnd_rsp_id_we k=%0d got=%0d/%b exp=%0d/%b", k, bus.rsp_id, bus.rsp_we, e_rsp.id, e_rsp.we); else n_pass++;
        n_checks++; if (bus.rsp_rdata !== e_rsp.rdata) $display("FAIL rnd_rsp_rdata k=%0d got=%h exp=%h", k, bus.rsp_rdata, e_rsp.rdata); else n_pass++;
      end
      n_checks++; if (bus.lock_err !== m_err_exp) $display("FAIL rnd_lock_err k=%0d got=%b exp=%b", k, bus.lock_err, m_err_exp); else n_pass++;
      n_checks++; if (bus.spr_we_ !== !e_spr_wr) $display("FAIL rnd_spr_we_ k=%0d got=%b exp=%b", k, bus.spr_we_, !e_spr_wr); else n_pass++;
      if (e_spr_wr) begin
        n_checks++; if ({bus.spr_w_addr, bus.spr_w_data} !== {ADDR_W'(iss_addr), iss_wdata}) $display("FAIL rnd_spr_write k=%0d got=%0d:%h exp=%0d:%h", k, bus.spr_w_addr, bus.spr_w_data, iss_addr, iss_wdata); else n_pass++;
      end
      cyc_end();
      if (e_win >= 0) pend[e_win] = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    m_cyc = 0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_round_robin();
    test_lock();
    test_lock_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
